bin_unloader: RTL



---
 rtl/sat_bin_pkg.sv | 39 +++
 rtl/state_serializer.sv | 52 +++++
 rtl/bin_unloader.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/sat_bin_pkg.sv
// Shared types and helpers for the bin manager <-> core transfer engines.
// Holds the unloader FSM state encoding, default geometry constants and the
// bin-relative RAM address helper.
package sat_bin_pkg;

    localparam int DEF_NUM_CLAUSES_A_BIN     = 8;
    localparam int DEF_NUM_VARS_A_BIN        = 8;
    localparam int DEF_NUM_LVLS_A_BIN        = 8;
    localparam int DEF_WIDTH_BIN_ID          = 10;
    localparam int DEF_WIDTH_VAR_STATES      = 11;
    localparam int DEF_WIDTH_LVL_STATES      = 19;
    localparam int DEF_ADDR_WIDTH_CLAUSES    = 9;
    localparam int DEF_ADDR_WIDTH_VAR_STATES = 9;
    localparam int DEF_ADDR_WIDTH_LVL_STATES = 9;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLAUSE,
        ST_VAR,
        ST_LVL,
        ST_DONE
    } state_t;

    // Slot address of entry idx inside bin bin_id, where every bin owns n
    // consecutive slots. The product is formed at full width and then wrapped
    // to the aw-bit RAM address space.
    function automatic logic [31:0] bin_addr(input logic [31:0] bin_id,
                                             input logic [31:0] idx,
                                             input logic [31:0] n,
                                             input int          aw);
        logic [31:0] full;
        full = bin_id * n + idx;
        if (aw < 32) begin
            return full & ((32'd1 << aw) - 32'd1);
        end
        return full;
    endfunction

endpackage

// File: rtl/state_serializer.sv
// Parallel-in / serial-out state writer. Snapshots a packed array of DEPTH
// words on i_load, then while i_run is high emits one word per cycle
// (index 0 first) together with its index and a last-word flag.
module state_serializer
    import sat_bin_pkg::*;
#(
    parameter  int WIDTH = DEF_WIDTH_VAR_STATES,
    parameter  int DEPTH = DEF_NUM_VARS_A_BIN,
    localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_load,
    input  logic [WIDTH*DEPTH-1:0] i_load_data,
    input  logic                   i_run,
    output logic                   o_en,
    output logic [IW-1:0]          o_idx,
    output logic [WIDTH-1:0]       o_data,
    output logic                   o_last
);

    logic [WIDTH*DEPTH-1:0] r_snap;
    logic [IW-1:0]          r_idx;

    // Capture the whole state array at the moment the unload is accepted.
    // NOTE: the snapshot is a flop bank (not a RAM), so it is reset like any
    // other state; sequential blocks use non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_snap <= '0;
        end else if (i_load) begin
            r_snap <= i_load_data;
        end
    end

    // Word index: parked at 0 while idle, advances once per emitted word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx <= '0;
        end else if (!i_run || o_last) begin
            r_idx <= '0;
        end else begin
            r_idx <= r_idx + IW'(1);
        end
    end

    assign o_en   = i_run;
    assign o_idx  = r_idx;
    assign o_data = r_snap[r_idx*WIDTH +: WIDTH];
    assign o_last = (r_idx == IW'(DEPTH - 1));

endmodule

// File: rtl/bin_unloader.sv
// Core-to-bin-manager writeback engine. On start it snapshots the core's
// var/lvl states, reads the bin's clauses back through a two-stage pipeline
// (read select, capture, write) and then streams var and lvl states into the
// bin manager RAMs at the slots owned by the current bin.
// Optional build macro BIN_UNLOAD_ABORT_EN adds abort_i, which drops any
// running unload back to IDLE without done_o.
module bin_unloader
    import sat_bin_pkg::*;
#(
    parameter  int NUM_CLAUSES_A_BIN     = DEF_NUM_CLAUSES_A_BIN,
    parameter  int NUM_VARS_A_BIN        = DEF_NUM_VARS_A_BIN,
    parameter  int NUM_LVLS_A_BIN        = DEF_NUM_LVLS_A_BIN,
    parameter  int WIDTH_BIN_ID          = DEF_WIDTH_BIN_ID,
    parameter  int WIDTH_CLAUSES         = NUM_VARS_A_BIN * 2,
    parameter  int WIDTH_VAR_STATES      = DEF_WIDTH_VAR_STATES,
    parameter  int WIDTH_LVL_STATES      = DEF_WIDTH_LVL_STATES,
    parameter  int ADDR_WIDTH_CLAUSES    = DEF_ADDR_WIDTH_CLAUSES,
    parameter  int ADDR_WIDTH_VAR_STATES = DEF_ADDR_WIDTH_VAR_STATES,
    parameter  int ADDR_WIDTH_LVL_STATES = DEF_ADDR_WIDTH_LVL_STATES,
    localparam int NCW                   = $clog2(NUM_CLAUSES_A_BIN + 1),
    localparam int VIW                   = (NUM_VARS_A_BIN > 1) ? $clog2(NUM_VARS_A_BIN) : 1,
    localparam int LIW                   = (NUM_LVLS_A_BIN > 1) ? $clog2(NUM_LVLS_A_BIN) : 1
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   start_i,
`ifdef BIN_UNLOAD_ABORT_EN
    input  logic                                   abort_i,
`endif
    input  logic [WIDTH_BIN_ID-1:0]                bin_id_i,
    input  logic [NCW-1:0]                         nc_bin_i,
    output logic                                   done_o,
    output logic                                   busy_o,
    output logic [NUM_CLAUSES_A_BIN-1:0]           rd_carray_o,
    input  logic [WIDTH_CLAUSES-1:0]               clause_i,
    input  logic [WIDTH_VAR_STATES*NUM_VARS_A_BIN-1:0] vars_states_i,
    input  logic [WIDTH_LVL_STATES*NUM_LVLS_A_BIN-1:0] lvl_states_i,
    output logic                                   wr_clause_en_o,
    output logic [ADDR_WIDTH_CLAUSES-1:0]          wr_clause_addr_o,
    output logic [WIDTH_CLAUSES-1:0]               wr_clause_data_o,
    output logic                                   wr_vs_en_o,
    output logic [ADDR_WIDTH_VAR_STATES-1:0]       wr_vs_addr_o,
    output logic [WIDTH_VAR_STATES-1:0]            wr_vs_data_o,
    output logic                                   wr_ls_en_o,
    output logic [ADDR_WIDTH_LVL_STATES-1:0]       wr_ls_addr_o,
    output logic [WIDTH_LVL_STATES-1:0]            wr_ls_data_o
);

    state_t r_state;
    state_t w_state_next;

    logic [WIDTH_BIN_ID-1:0]  r_bin_id;
    logic [NCW-1:0]           r_nc;
    logic [NCW-1:0]           w_nc_sat;
    logic                     w_start;
    logic                     w_abort;

    // Clause pipeline: stage 1 remembers which read was issued last cycle,
    // stage 2 holds the captured clause word being written this cycle.
    logic [NCW-1:0]           r_rd_cnt;
    logic                     w_rd_issue;
    logic                     r_p1_vld;
    logic                     r_p1_last;
    logic [NCW-1:0]           r_p1_idx;
    logic                     r_wr_vld;
    logic                     r_wr_last;
    logic [NCW-1:0]           r_wr_idx;
    logic [WIDTH_CLAUSES-1:0] r_wr_data;

    logic                        w_vs_en;
    logic [VIW-1:0]              w_vs_idx;
    logic [WIDTH_VAR_STATES-1:0] w_vs_data;
    logic                        w_vs_last;
    logic                        w_ls_en;
    logic [LIW-1:0]              w_ls_idx;
    logic [WIDTH_LVL_STATES-1:0] w_ls_data;
    logic                        w_ls_last;

    assign w_nc_sat   = (nc_bin_i > NCW'(NUM_CLAUSES_A_BIN)) ? NCW'(NUM_CLAUSES_A_BIN) : nc_bin_i;
    assign w_start    = (r_state == ST_IDLE) && start_i;
    assign w_rd_issue = (r_state == ST_CLAUSE) && (r_rd_cnt < r_nc);

`ifdef BIN_UNLOAD_ABORT_EN
    assign w_abort = abort_i && (r_state != ST_IDLE);
`else
    assign w_abort = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Latch the bin id and saturated clause count when a start is accepted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_bin_id <= '0;
            r_nc     <= '0;
        end else if (w_start) begin
            r_bin_id <= bin_id_i;
            r_nc     <= w_nc_sat;
        end
    end

    // Clause read/capture pipeline; flushed whenever the FSM is not in CLAUSE
    // so an aborted or reset run never leaks a stale write into the next one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd_cnt  <= '0;
            r_p1_vld  <= 1'b0;
            r_p1_last <= 1'b0;
            r_p1_idx  <= '0;
            r_wr_vld  <= 1'b0;
            r_wr_last <= 1'b0;
            r_wr_idx  <= '0;
            r_wr_data <= '0;
        end else if (r_state != ST_CLAUSE) begin
            r_rd_cnt  <= '0;
            r_p1_vld  <= 1'b0;
            r_p1_last <= 1'b0;
            r_p1_idx  <= '0;
            r_wr_vld  <= 1'b0;
            r_wr_last <= 1'b0;
            r_wr_idx  <= '0;
            r_wr_data <= '0;
        end else begin
            r_rd_cnt  <= r_rd_cnt + NCW'(w_rd_issue);
            r_p1_vld  <= w_rd_issue;
            r_p1_last <= w_rd_issue && ((r_rd_cnt + NCW'(1)) == r_nc);
            r_p1_idx  <= r_rd_cnt;
            r_wr_vld  <= r_p1_vld;
            r_wr_last <= r_p1_last;
            r_wr_idx  <= r_p1_idx;
            r_wr_data <= clause_i;
        end
    end

    state_serializer #(
        .WIDTH (WIDTH_VAR_STATES),
        .DEPTH (NUM_VARS_A_BIN)
    ) u_vs_ser (
        .clk         (clk),
        .rst_n       (rst),
        .i_load      (w_start),
        .i_load_data (vars_states_i),
        .i_run       (r_state == ST_VAR),
        .o_en        (w_vs_en),
        .o_idx       (w_vs_idx),
        .o_data      (w_vs_data),
        .o_last      (w_vs_last)
    );

    state_serializer #(
        .WIDTH (WIDTH_LVL_STATES),
        .DEPTH (NUM_LVLS_A_BIN)
    ) u_ls_ser (
        .clk         (clk),
        .rst_n       (rst),
        .i_load      (w_start),
        .i_load_data (lvl_states_i),
        .i_run       (r_state == ST_LVL),
        .o_en        (w_ls_en),
        .o_idx       (w_ls_idx),
        .o_data      (w_ls_data),
        .o_last      (w_ls_last)
    );

    // Next-state and control outputs; only the current phase may drive its
    // read select or write enable, so at most one enable is high per cycle.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // through the case statement can infer a latch.
        w_state_next   = r_state;
        done_o         = 1'b0;
        busy_o         = (r_state != ST_IDLE);
        rd_carray_o    = '0;
        wr_clause_en_o = 1'b0;
        wr_vs_en_o     = 1'b0;
        wr_ls_en_o     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_state_next = (w_nc_sat == '0) ? ST_VAR : ST_CLAUSE;
                end
            end
            ST_CLAUSE: begin
                if (w_rd_issue) begin
                    rd_carray_o = NUM_CLAUSES_A_BIN'(1) << r_rd_cnt;
                end
                wr_clause_en_o = r_wr_vld;
                if (r_wr_vld && r_wr_last) begin
                    w_state_next = ST_VAR;
                end
            end
            ST_VAR: begin
                wr_vs_en_o = w_vs_en;
                if (w_vs_last) begin
                    w_state_next = ST_LVL;
                end
            end
            ST_LVL: begin
                wr_ls_en_o = w_ls_en;
                if (w_ls_last) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                done_o       = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
        if (w_abort) begin
            done_o       = 1'b0;
            w_state_next = ST_IDLE;
        end
    end

    assign wr_clause_data_o = r_wr_data;
    assign wr_vs_data_o     = w_vs_data;
    assign wr_ls_data_o     = w_ls_data;

    assign wr_clause_addr_o = ADDR_WIDTH_CLAUSES'(bin_addr(32'(r_bin_id), 32'(r_wr_idx),
                                  32'(NUM_CLAUSES_A_BIN), ADDR_WIDTH_CLAUSES));
    assign wr_vs_addr_o     = ADDR_WIDTH_VAR_STATES'(bin_addr(32'(r_bin_id), 32'(w_vs_idx),
                                  32'(NUM_VARS_A_BIN), ADDR_WIDTH_VAR_STATES));
    assign wr_ls_addr_o     = ADDR_WIDTH_LVL_STATES'(bin_addr(32'(r_bin_id), 32'(w_ls_idx),
                                  32'(NUM_LVLS_A_BIN), ADDR_WIDTH_LVL_STATES));

endmodule
